lock_input_frontend: RTL

Upstream input stage of the combination-lock FSM. It conditions the raw board pushbuttons and switches before the lock controller sees them.
- Synchronizes and debounces two active-low keys into single-cycle Enter/Change pulses.
- Captures the 4-bit switch code X in the same cycle each pulse is issued, so the lock's combinational compare (X vs stored combo, qualified by Enter/Change) is always glitch-free.

---
 rtl/lock_input_pkg.sv | 27 ++
 rtl/lock_key_debounce.sv | 103 ++++++++++
 rtl/lock_input_frontend.sv | 94 +++++++++
 3 files changed

// File: rtl/lock_input_pkg.sv
// Shared types and constants for the combination-lock input front end.
//
// Contents:
//   key_state_e    - per-key debounce FSM state (2-bit encoding)
//   DEFAULT_*      - default debounce length, synchronizer depth, code width
//   cnt_width()    - width of a counter that must hold 0..cycles
package lock_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // 10 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
  localparam int unsigned DEFAULT_DATA_W          = 4;

  // Bits needed to represent 0..cycles inclusive; never less than 1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles + 1 <= 2) return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/lock_key_debounce.sv
// Synchronizer + debounce FSM for one active-low pushbutton.
//
// Ports:
//   Clock     in   system clock, rising edge
//   Resetn    in   asynchronous active-low reset
//   key_n_i   in   raw active-low key, asynchronous and bouncing
//   accept_o  out  combinational one-cycle strobe on the edge a press is
//                  accepted (the caller registers it)
//
// The FSM state is held in state_q (key_state_e) for probing.
// SYNC_STAGES must be at least 2.
module lock_key_debounce
  import lock_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n_i,
  output logic accept_o
);

  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  // Synchronizer resets to the released level so reset never looks like a press.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_i};
  end

  assign key_s = sync_q[SYNC_STAGES-1];

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts consecutive samples at the new level; the accept/release
  // decision is taken on the DEBOUNCE_CYCLES-th such sample. The counter
  // saturates at DEBOUNCE_CYCLES rather than wrapping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d  = HELD;
          cnt_d    = '0;
          accept_o = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/lock_input_frontend.sv
// Input stage of the combination lock: turns two bouncing active-low keys
// into single-cycle Enter/Change pulses and captures the switch code X on
// the same edge, so X is stable whenever a pulse qualifies it.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Resetn       in   asynchronous active-low reset
//   KeyEnter_n   in   raw Enter key, active-low, bouncing
//   KeyChange_n  in   raw Change key, active-low, bouncing
//   SW           in   raw switch code [DATA_W]
//   X            out  registered code, reloaded only when a pulse is issued
//   Enter        out  one-cycle pulse per accepted Enter press
//   Change       out  one-cycle pulse per accepted Change press
//
// Enter and Change are qualifiers for X with no back-pressure: the lock
// samples X in exactly the cycle a pulse is high.
module lock_input_frontend
  import lock_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DATA_W          = DEFAULT_DATA_W
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              KeyEnter_n,
  input  logic              KeyChange_n,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] X,
  output logic              Enter,
  output logic              Change
);

  logic enter_acc;
  logic change_acc;

  lock_key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_enter_key (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .key_n_i  (KeyEnter_n),
    .accept_o (enter_acc)
  );

  lock_key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_change_key (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .key_n_i  (KeyChange_n),
    .accept_o (change_acc)
  );

  // Bitwise synchronization: skew between bits is harmless because X is only
  // loaded on an accept, long after the switches have settled.
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) sw_sync_q <= '0;
    else         sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], SW};
  end

  logic [DATA_W-1:0] x_q, x_d;
  logic              enter_q, enter_d;
  logic              change_q, change_d;

  // Enter wins a same-edge tie; the losing Change press is dropped, not queued.
  always_comb begin
    enter_d  = enter_acc;
    change_d = change_acc & ~enter_acc;
    x_d      = x_q;
    if (enter_acc || change_acc) x_d = sw_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      x_q      <= '0;
      enter_q  <= 1'b0;
      change_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      enter_q  <= enter_d;
      change_q <= change_d;
    end
  end

  assign X      = x_q;
  assign Enter  = enter_q;
  assign Change = change_q;

endmodule
